// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run/load sequencer.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_DRAIN_CYCLES = 4;

    // The CPU owns the data-memory port only while it is out of reset.
    function automatic logic cpu_owns(input state_e st);
        return (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_dmem_port_mux.sv
// Data-memory port owner select; the non-owner can never write.
module dmem_port_mux
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  state_e          state_i,
    input  logic            host_req_i,
    input  logic            host_we_i,
    input  logic [AW-1:0]   host_addr_i,
    input  logic [DW-1:0]   host_wdata_i,
    input  logic            cpu_we_i,
    input  logic [AW-1:0]   cpu_addr_i,
    input  logic [DW-1:0]   cpu_wdata_i,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic            mem_we_o
);

    // Route the owner's address/data and gate the write enable.
    always_comb begin
        mem_addr_o  = host_addr_i;
        mem_wdata_o = host_wdata_i;
        mem_we_o    = 1'b0;
        if (cpu_owns(state_i)) begin
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
            mem_we_o    = cpu_we_i;
        end else begin
            mem_we_o    = host_req_i & host_we_i;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run/load sequencer: owns CPU reset and the data-memory port.
// Optional watchdog enabled by defining RUN_CTRL_TIMEOUT_EN.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int DW           = 32,
    parameter int AW           = 32,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
`ifdef RUN_CTRL_TIMEOUT_EN
    parameter int MAX_CYCLES   = 1000000,
`endif
    parameter int CW           = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            host_start_i,
    input  logic            host_clear_i,
    input  logic [AW-1:0]   halt_addr_i,
    input  logic            host_req_i,
    input  logic            host_we_i,
    input  logic [AW-1:0]   host_addr_i,
    input  logic [DW-1:0]   host_wdata_i,
    output logic            host_ack_o,
    output logic [DW-1:0]   host_rdata_o,
    output logic            cpu_rst_o,
    input  logic [AW-1:0]   cpu_pc_i,
    input  logic [AW-1:0]   cpu_addr_i,
    input  logic [DW-1:0]   cpu_wdata_i,
    input  logic            cpu_we_i,
    output logic [DW-1:0]   cpu_rdata_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic            mem_we_o,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic [1:0]      state_o,
`ifdef RUN_CTRL_TIMEOUT_EN
    output logic            timeout_o,
`endif
    output logic            done_o,
    output logic [CW-1:0]   cycle_count_o
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e          state_q, state_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic [CW-1:0]   cycle_count_q, cycle_count_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            done_q, done_d;
    logic            host_ack_q, host_ack_d;
    logic [DW-1:0]   host_rdata_q, host_rdata_d;
    logic            host_own_s;
`ifdef RUN_CTRL_TIMEOUT_EN
    logic            timeout_q, timeout_d;
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == {CW{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CW-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-state, counters and registered-output logic.
    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        cycle_count_d = cycle_count_q;
`ifdef RUN_CTRL_TIMEOUT_EN
        timeout_d     = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (host_start_i) begin
                    state_d       = ST_RUN;
                    cycle_count_d = {CW{1'b0}};
`ifdef RUN_CTRL_TIMEOUT_EN
                    timeout_d     = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                cycle_count_d = sat_inc(cycle_count_q);
                if (cpu_pc_i == halt_addr_i) begin
                    state_d = ST_DRAIN;
                    drain_d = DCW'(DRAIN_CYCLES - 1);
`ifdef RUN_CTRL_TIMEOUT_EN
                end else if (cycle_count_q == CW'(MAX_CYCLES - 1)) begin
                    state_d   = ST_DRAIN;
                    drain_d   = DCW'(DRAIN_CYCLES - 1);
                    timeout_d = 1'b1;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                cycle_count_d = sat_inc(cycle_count_q);
                if (drain_q == {DCW{1'b0}}) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - {{(DCW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                // Clear has priority over a simultaneous start.
                if (host_clear_i) begin
                    state_d = ST_IDLE;
`ifdef RUN_CTRL_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end else if (host_start_i) begin
                    state_d       = ST_RUN;
                    cycle_count_d = {CW{1'b0}};
`ifdef RUN_CTRL_TIMEOUT_EN
                    timeout_d     = 1'b0;
`endif
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cpu_rst_d    = !cpu_owns(state_d);
        done_d       = (state_d == ST_DONE);
        host_own_s   = !cpu_owns(state_q);
        host_ack_d   = host_req_i & host_own_s;
        host_rdata_d = host_ack_d ? mem_rdata_i : host_rdata_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            drain_q       <= {DCW{1'b0}};
            cycle_count_q <= {CW{1'b0}};
            cpu_rst_q     <= 1'b1;
            done_q        <= 1'b0;
            host_ack_q    <= 1'b0;
            host_rdata_q  <= {DW{1'b0}};
`ifdef RUN_CTRL_TIMEOUT_EN
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            cycle_count_q <= cycle_count_d;
            cpu_rst_q     <= cpu_rst_d;
            done_q        <= done_d;
            host_ack_q    <= host_ack_d;
            host_rdata_q  <= host_rdata_d;
`ifdef RUN_CTRL_TIMEOUT_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

    dmem_port_mux #(
        .DW (DW),
        .AW (AW)
    ) u_mux (
        .state_i      (state_q),
        .host_req_i   (host_req_i),
        .host_we_i    (host_we_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_we_o     (mem_we_o)
    );

    assign cpu_rdata_o   = mem_rdata_i;
    assign host_ack_o    = host_ack_q;
    assign host_rdata_o  = host_rdata_q;
    assign cpu_rst_o     = cpu_rst_q;
    assign done_o        = done_q;
    assign state_o       = state_q;
    assign cycle_count_o = cycle_count_q;
`ifdef RUN_CTRL_TIMEOUT_EN
    assign timeout_o     = timeout_q;
`endif

endmodule
